// File: rtl/jtcontra_colmix_multi.sv
// Multi-layer colour mixer: rotating-priority layer merge, xBGR555 palette lookup, dim and blanking.
// Three pxl_cen-gated stages; palette word is read once, on the clk after each S2 address update.
module jtcontra_colmix_multi #(
  parameter int AW     = 12,
  parameter int LAYERS = 2,
  parameter int PW     = 7
) (
  input  logic                 rst,
  input  logic                 clk,
  input  logic                 pxl_cen,
  input  logic                 cpu_cen,
  input  logic                 LHBL,
  input  logic                 LVBL,
  output logic                 LHBL_dly,
  output logic                 LVBL_dly,
  input  logic                 pal_cs,
  input  logic                 cpu_rnw,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [7:0]           cpu_dout,
  output logic [7:0]           pal_dout,
  input  logic [LAYERS*PW-1:0] pxl_in,
  input  logic [1:0]           prio,
  input  logic                 dim,
  output logic [4:0]           red,
  output logic [4:0]           green,
  output logic [4:0]           blue
);

  localparam int IW    = AW - 1;
  localparam int DEPTH = 1 << IW;

  // Low and high bytes kept in separate arrays so the pixel port gets a full word per read
  logic [7:0] pal_lo [DEPTH];
  logic [7:0] pal_hi [DEPTH];

  logic          pal_we;
  logic [IW-1:0] cpu_idx;
  assign pal_we  = pal_cs & ~cpu_rnw & cpu_cen;
  assign cpu_idx = cpu_addr[AW-1:1];

  always_ff @(posedge clk) begin
    if (pal_we) begin
      if (cpu_addr[0]) pal_hi[cpu_idx] <= cpu_dout;
      else             pal_lo[cpu_idx] <= cpu_dout;
    end
  end

  logic [LAYERS*PW-1:0] pxl_q, pxl_d;
  logic [1:0]           prio_q, prio_d;
  logic                 dim1_q, dim1_d, hb1_q, hb1_d, vb1_q, vb1_d;
  logic [IW-1:0]        addr_q, addr_d;
  logic                 dim2_q, dim2_d, hb2_q, hb2_d, vb2_q, vb2_d;
  logic                 rd_q, rd_d;
  logic [15:0]          word_q, word_d;
  logic [4:0]           red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic                 hb3_q, hb3_d, vb3_q, vb3_d;
  logic [7:0]           pal_dout_q, pal_dout_d;

  function automatic logic [4:0] shade(input logic [4:0] c, input logic d);
    return d ? {1'b0, c[4:1]} : c;
  endfunction

  // First opaque layer walking cyclically from prio; backdrop entry 0 when none
  logic [IW-1:0] win_idx;
  logic          found;
  logic [2:0]    lyr;
  logic [PW-1:0] pix;
  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    lyr     = '0;
    pix     = '0;
    for (int i = 0; i < LAYERS; i++) begin
      lyr = 3'((int'(prio_q) + i) % LAYERS);
      pix = pxl_q[int'(lyr)*PW +: PW];
      if (!found && pix[3:0] != 4'd0) begin
        found   = 1'b1;
        win_idx = IW'({lyr[1:0], pix});
      end
    end
  end

  always_comb begin
    pxl_d      = pxl_q;
    prio_d     = prio_q;
    dim1_d     = dim1_q;
    hb1_d      = hb1_q;
    vb1_d      = vb1_q;
    addr_d     = addr_q;
    dim2_d     = dim2_q;
    hb2_d      = hb2_q;
    vb2_d      = vb2_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    hb3_d      = hb3_q;
    vb3_d      = vb3_q;
    rd_d       = pxl_cen;
    word_d     = rd_q ? {pal_hi[addr_q], pal_lo[addr_q]} : word_q;
    pal_dout_d = cpu_addr[0] ? pal_hi[cpu_idx] : pal_lo[cpu_idx];
    if (pxl_cen) begin
      pxl_d   = pxl_in;
      prio_d  = prio;
      dim1_d  = dim;
      hb1_d   = LHBL;
      vb1_d   = LVBL;
      addr_d  = win_idx;
      dim2_d  = dim1_q;
      hb2_d   = hb1_q;
      vb2_d   = vb1_q;
      hb3_d   = hb2_q;
      vb3_d   = vb2_q;
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      if (hb2_q & vb2_q) begin
        red_d   = shade(word_q[4:0],   dim2_q);
        green_d = shade(word_q[9:5],   dim2_q);
        blue_d  = shade(word_q[14:10], dim2_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pxl_q      <= '0;
      prio_q     <= '0;
      dim1_q     <= 1'b0;
      hb1_q      <= 1'b0;
      vb1_q      <= 1'b0;
      addr_q     <= '0;
      dim2_q     <= 1'b0;
      hb2_q      <= 1'b0;
      vb2_q      <= 1'b0;
      rd_q       <= 1'b0;
      word_q     <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      hb3_q      <= 1'b0;
      vb3_q      <= 1'b0;
      pal_dout_q <= '0;
    end else begin
      pxl_q      <= pxl_d;
      prio_q     <= prio_d;
      dim1_q     <= dim1_d;
      hb1_q      <= hb1_d;
      vb1_q      <= vb1_d;
      addr_q     <= addr_d;
      dim2_q     <= dim2_d;
      hb2_q      <= hb2_d;
      vb2_q      <= vb2_d;
      rd_q       <= rd_d;
      word_q     <= word_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      hb3_q      <= hb3_d;
      vb3_q      <= vb3_d;
      pal_dout_q <= pal_dout_d;
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign LHBL_dly = hb3_q;
  assign LVBL_dly = vb3_q;
  assign pal_dout = pal_dout_q;

endmodule

// File: tb/tb_jtcontra_colmix_multi.sv
// Directed bench for jtcontra_colmix_multi (AW=12, LAYERS=2, PW=7) with hand-computed expectations.
module tb_jtcontra_colmix_multi;
  logic        rst, clk, pxl_cen, cpu_cen, LHBL, LVBL;
  logic        LHBL_dly, LVBL_dly, pal_cs, cpu_rnw, dim;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_dout, pal_dout;
  logic [13:0] pxl_in;
  logic [1:0]  prio;
  logic [4:0]  red, green, blue;

  int errors = 0;
  int checks = 0;

  jtcontra_colmix_multi #(.AW(12), .LAYERS(2), .PW(7)) dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .cpu_cen(cpu_cen),
    .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
    .pal_cs(pal_cs), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .pal_dout(pal_dout), .pxl_in(pxl_in), .prio(prio), .dim(dim),
    .red(red), .green(green), .blue(blue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    chk({tag, ".red"},   32'(red),   32'(r));
    chk({tag, ".green"}, 32'(green), 32'(g));
    chk({tag, ".blue"},  32'(blue),  32'(b));
  endtask

  task automatic pulse();
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run3();
    repeat (3) pulse();
  endtask

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = a; cpu_dout = d;
    @(negedge clk);
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [7:0] e);
    cpu_addr = a;
    @(negedge clk);
    chk(tag, 32'(pal_dout), 32'(e));
  endtask

  task automatic set_px(input logic [6:0] l1, input logic [6:0] l0, input logic [1:0] p, input logic d);
    pxl_in = {l1, l0};
    prio   = p;
    dim    = d;
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; cpu_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1;
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = '0;
    pxl_in = '0; prio = '0; dim = 1'b0;
    repeat (3) @(negedge clk);
    chk_rgb("reset", 5'd0, 5'd0, 5'd0);
    chk("reset.pal_dout", 32'(pal_dout), 32'h0);
    chk("reset.LHBL_dly", 32'(LHBL_dly), 32'h0);
    chk("reset.LVBL_dly", 32'(LVBL_dly), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Entry 1 = red, entry 0 = white, entry 0x82 = green, entry 3 = blue
    wr(12'h002, 8'h1F); wr(12'h003, 8'h00);
    wr(12'h000, 8'hFF); wr(12'h001, 8'h7F);
    wr(12'h104, 8'hE0); wr(12'h105, 8'h03);
    wr(12'h006, 8'h00); wr(12'h007, 8'h7C);
    rd_chk("rd.addr2", 12'h002, 8'h1F);
    rd_chk("rd.addr105", 12'h105, 8'h03);

    // Read in the same clk as a write returns the old byte
    wr(12'h008, 8'h11);
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = 12'h008; cpu_dout = 8'h22;
    @(negedge clk);
    chk("rdw.old", 32'(pal_dout), 32'h11);
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
    @(negedge clk);
    chk("rdw.new", 32'(pal_dout), 32'h22);
    // No write without cpu_cen
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_dout = 8'h33;
    @(negedge clk);
    pal_cs = 1'b0; cpu_rnw = 1'b1;
    rd_chk("nocen", 12'h008, 8'h22);

    // Latency: nothing after two pulses, red after the third
    set_px(7'h00, 7'h01, 2'd0, 1'b0);
    pulse(); pulse();
    chk_rgb("lat2", 5'd0, 5'd0, 5'd0);
    chk("lat2.LHBL_dly", 32'(LHBL_dly), 32'h0);
    pulse();
    chk_rgb("lat3", 5'd31, 5'd0, 5'd0);
    chk("lat3.LHBL_dly", 32'(LHBL_dly), 32'h1);
    chk("lat3.LVBL_dly", 32'(LVBL_dly), 32'h1);

    set_px(7'h02, 7'h01, 2'd0, 1'b0); run3();
    chk_rgb("prio0", 5'd31, 5'd0, 5'd0);
    set_px(7'h02, 7'h01, 2'd1, 1'b0); run3();
    chk_rgb("prio1", 5'd0, 5'd31, 5'd0);
    set_px(7'h02, 7'h01, 2'd2, 1'b0); run3();
    chk_rgb("prio2mod", 5'd31, 5'd0, 5'd0);
    set_px(7'h02, 7'h01, 2'd3, 1'b0); run3();
    chk_rgb("prio3mod", 5'd0, 5'd31, 5'd0);
    set_px(7'h02, 7'h10, 2'd0, 1'b0); run3();
    chk_rgb("transp0", 5'd0, 5'd31, 5'd0);
    set_px(7'h10, 7'h10, 2'd0, 1'b0); run3();
    chk_rgb("backdrop", 5'd31, 5'd31, 5'd31);
    set_px(7'h10, 7'h10, 2'd0, 1'b1); run3();
    chk_rgb("dim", 5'd15, 5'd15, 5'd15);

    // Holding pxl_cen low freezes outputs
    set_px(7'h00, 7'h01, 2'd0, 1'b0);
    repeat (10) @(negedge clk);
    chk_rgb("hold", 5'd15, 5'd15, 5'd15);
    set_px(7'h10, 7'h10, 2'd0, 1'b1);

    LHBL = 1'b0;
    pulse(); pulse();
    chk("hblk2.LHBL_dly", 32'(LHBL_dly), 32'h1);
    chk_rgb("hblk2", 5'd15, 5'd15, 5'd15);
    pulse();
    chk("hblk3.LHBL_dly", 32'(LHBL_dly), 32'h0);
    chk("hblk3.LVBL_dly", 32'(LVBL_dly), 32'h1);
    chk_rgb("hblk3", 5'd0, 5'd0, 5'd0);
    LHBL = 1'b1;
    set_px(7'h10, 7'h10, 2'd0, 1'b0); run3();
    chk_rgb("unblank", 5'd31, 5'd31, 5'd31);

    // Mid-line reset
    rst = 1'b1;
    #1;
    chk_rgb("midrst", 5'd0, 5'd0, 5'd0);
    chk("midrst.LHBL_dly", 32'(LHBL_dly), 32'h0);
    chk("midrst.pal_dout", 32'(pal_dout), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    pulse(); pulse();
    chk_rgb("postrst2", 5'd0, 5'd0, 5'd0);
    chk("postrst2.LVBL_dly", 32'(LVBL_dly), 32'h0);
    pulse();
    chk_rgb("postrst3", 5'd31, 5'd31, 5'd31);
    rd_chk("retain.addr2", 12'h002, 8'h1F);
    rd_chk("retain.addr1", 12'h001, 8'h7F);

    // Write landing on the pixel-port read clk
    set_px(7'h00, 7'h03, 2'd0, 1'b0); run3();
    chk_rgb("coll.pre", 5'd0, 5'd0, 5'd31);
    pxl_cen = 1'b1;
    @(negedge clk);
    pxl_cen = 1'b0;
    pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = 12'h006; cpu_dout = 8'h1F;
    @(negedge clk);
    pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
    @(negedge clk);
    pulse();
    chk_rgb("coll.old", 5'd0, 5'd0, 5'd31);
    pulse();
    chk_rgb("coll.new", 5'd31, 5'd0, 5'd31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtcontra_colmix_multi.md
# jtcontra_colmix_multi

Parametrised colour mixer for the Konami 007121-family cores: the successor of the single-layer, fixed-format colour mixers used by the per-game video tops. It merges up to four tile/object layer pixel streams with rotatable priority and looks the winning pixel up in a CPU-writable xBGR555 palette. It outputs blanked 5-bit RGB aligned to delayed blanking signals. It sits between the jtcontra_gfx instance(s) and the video output of a game's video top.

## Interface
Parameters:
- AW, 12, CPU palette byte-address width; palette holds 2^(AW-1) 16-bit entries
- LAYERS, 2, number of layer inputs, legal 1..4
- PW, 7, pixel index width per layer; must satisfy PW+2 <= AW-1

Ports:
- rst  in  1  asynchronous reset, active high
- clk  in  1  system clock, 48 MHz; the block's only clock
- pxl_cen  in  1  pixel clock enable; at least 2 clk between pulses
- cpu_cen  in  1  CPU clock enable, qualifies writes
- LHBL, LVBL  in  1  active-low blanking from timing generator
- LHBL_dly, LVBL_dly  out  1  blanking aligned to RGB output
- pal_cs  in  1  palette chip select
- cpu_rnw  in  1  1 = read, 0 = write
- cpu_addr  in  AW  palette byte address
- cpu_dout  in  8  CPU write data
- pal_dout  out  8  palette read data
- pxl_in  in  LAYERS*PW  layer n pixel at bits [n*PW +: PW]
- prio  in  2  highest-priority layer number; priority descends cyclically
- dim  in  1  shadow mode; halves every component
- red, green, blue  out  5  colour output

## Operation
- Palette: dual-port byte RAM, 2^AW bytes, not reset. Entry k is byte 2k (low) plus byte 2k+1 (high).
  - Low byte = {G[2:0], R[4:0]}. High byte = {unused, B[4:0], G[4:3]}.
- CPU write: one byte at cpu_addr is written on each clk where pal_cs & ~cpu_rnw & cpu_cen.
- CPU read: pal_dout is registered every clk from cpu_addr, so data appears 1 clk after the address. A read in the same clk as a write to that address returns the old byte.
- Transparency: a layer pixel is transparent when its low 4 bits are 0.
- Priority order is prio, prio+1, ..., wrapping modulo LAYERS. A prio value >= LAYERS is taken modulo LAYERS.
- The winner is the first non-transparent layer in priority order. The palette index is {layer[1:0], pixel[PW-1:0]}, zero-extended to AW-1 bits.
- If all layers are transparent, the index is 0 (backdrop).
- dim: the output component is comp>>1, sampled in the same stage as the palette data.
- Blanking: RGB is forced to 0 when LHBL_dly & LVBL_dly is 0.

## Timing
- Pipeline stages, each advancing only on pxl_cen:
  - S1 registers pxl_in, prio, dim, LHBL and LVBL.
  - S2 computes the winner and presents the palette address. The pixel-port RAM output is registered on the following clk.
  - S3 latches the palette word, applies dim and blanking, and registers red/green/blue.
- Latency: pxl_in to RGB is exactly 3 pxl_cen pulses. LHBL_dly and LVBL_dly are LHBL and LVBL delayed by exactly 3 pxl_cen pulses.
- A CPU write to an entry in use by the pixel port shows on screen from the next S2 lookup. The pixel-port read returns the old value in the colliding clk.
- Reset values: red, green, blue, pal_dout, LHBL_dly and LVBL_dly are all 0. All pipeline registers are 0.
- Reset mid-frame: the pipeline clears and the output stays black until 3 pxl_cen pulses after rst falls. Palette contents are retained.
- With pxl_cen held low, all outputs hold. CPU access still operates.

## Test plan
- Write bytes 0x1F,0x00 at addresses 2,3 with pal_cs=1 and cpu_rnw=0 across cpu_cen pulses, then read address 2 -> pal_dout=0x1F one clk after the address. Then drive layer0 pixel 0x01 with LAYERS=2 and prio=0 -> red=31, green=0, blue=0 exactly 3 pxl_cen later.
- Drive layer0=0x01 and layer1=0x02 with prio=0 -> index 0x001 is used. Change to prio=1 -> index {01,0x02}=0x082 is used.
- Drive both layers with values whose low nibble is 0 (e.g. 0x10) -> entry 0 is used. Entry 0=0x7FFF gives RGB 31,31,31.
- Set dim=1 on entry 0x7FFF -> RGB 15,15,15. Drive LHBL=0 -> RGB 0,0,0, and LHBL_dly falls exactly 3 pxl_cen after LHBL.
- Assert rst mid-line while RGB is non-zero -> all outputs are 0 immediately and remain 0 for 3 pxl_cen after release. Reading back any written palette byte afterwards returns the pre-reset value.
- Write an entry in the same clk its pixel-port read occurs -> the current pixel shows the old colour and the next pixel shows the new colour.
